// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider.
// Covers FSM states, result-ready levels and the start level.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left and trial-subtract.
// Purely combinational; the divider iterates it once per cycle.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              dividend_msb,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] new_rem,
   output logic              q_bit
);

   logic [DATA_W:0] shifted_s;
   logic [DATA_W:0] diff_s;

   // The top bit of the extended difference is the borrow of the trial subtract.
   always_comb begin
      shifted_s = {rem, dividend_msb};
      diff_s    = shifted_s - {1'b0, divisor};
      if (diff_s[DATA_W] == 1'b0) begin
         new_rem = diff_s[DATA_W-1:0];
         q_bit   = 1'b1;
      end else begin
         new_rem = shifted_s[DATA_W-1:0];
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for EX: restoring division on operand magnitudes,
// signs fixed up on completion; result = {remainder, quotient}.
module div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  signed_div,
   input  logic                  annul,
   input  logic [DATA_W-1:0]     opdata1,
   input  logic [DATA_W-1:0]     opdata2,
   output logic [2*DATA_W-1:0]   result,
   output logic                  ready,
   output logic                  stallreq
);
   import div_unit_pkg::*;

   div_state_e          state_r;
   div_state_e          state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [DATA_W-1:0]   dividend_r;
   logic [DATA_W-1:0]   divisor_r;
   logic [DATA_W-1:0]   rem_r;
   logic                neg_q_r;
   logic                neg_rem_r;
   logic                ready_r;
   logic [2*DATA_W-1:0] result_r;

   logic [DATA_W-1:0]   mag1_s;
   logic [DATA_W-1:0]   mag2_s;
   logic [DATA_W-1:0]   step_rem_s;
   logic                step_q_s;
   logic [DATA_W-1:0]   quot_s;
   logic [DATA_W-1:0]   quot_fix_s;
   logic [DATA_W-1:0]   rem_fix_s;
   logic                last_step_s;
   logic                div_zero_s;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem          (rem_r),
      .dividend_msb (dividend_r[DATA_W-1]),
      .divisor      (divisor_r),
      .new_rem      (step_rem_s),
      .q_bit        (step_q_s)
   );

   // Operand magnitudes at load and sign fix-up of the final step's outputs.
   // 0x80000000 negates to itself and is then treated as an unsigned magnitude.
   always_comb begin
      if (signed_div && opdata1[DATA_W-1]) begin
         mag1_s = -opdata1;
      end else begin
         mag1_s = opdata1;
      end
      if (signed_div && opdata2[DATA_W-1]) begin
         mag2_s = -opdata2;
      end else begin
         mag2_s = opdata2;
      end
      quot_s = {dividend_r[DATA_W-2:0], step_q_s};
      if (neg_q_r) begin
         quot_fix_s = -quot_s;
      end else begin
         quot_fix_s = quot_s;
      end
      if (neg_rem_r) begin
         rem_fix_s = -step_rem_s;
      end else begin
         rem_fix_s = step_rem_s;
      end
      last_step_s = (cnt_r == CNT_W'(DATA_W - 1));
      div_zero_s  = (opdata2 == {DATA_W{1'b0}});
   end

   // Next-state logic; annul overrides every state.
   always_comb begin
      state_nxt_s = state_r;
      if (annul) begin
         state_nxt_s = DivFree;
      end else begin
         case (state_r)
            DivFree: begin
               if (start == DivStart) begin
                  if (div_zero_s) begin
                     state_nxt_s = DivByZero;
                  end else begin
                     state_nxt_s = DivOn;
                  end
               end else begin
                  state_nxt_s = DivFree;
               end
            end
            DivByZero: state_nxt_s = DivEnd;
            DivOn: begin
               if (last_step_s) begin
                  state_nxt_s = DivEnd;
               end else begin
                  state_nxt_s = DivOn;
               end
            end
            DivEnd:  state_nxt_s = DivFree;
            default: state_nxt_s = DivFree;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DivFree;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath: ready is raised on the transition into END so it is high only in END.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= {CNT_W{1'b0}};
         dividend_r <= {DATA_W{1'b0}};
         divisor_r  <= {DATA_W{1'b0}};
         rem_r      <= {DATA_W{1'b0}};
         neg_q_r    <= 1'b0;
         neg_rem_r  <= 1'b0;
         ready_r    <= DivResultNotReady;
         result_r   <= {(2*DATA_W){1'b0}};
      end else if (annul) begin
         cnt_r    <= {CNT_W{1'b0}};
         ready_r  <= DivResultNotReady;
         result_r <= {(2*DATA_W){1'b0}};
      end else begin
         ready_r <= DivResultNotReady;
         case (state_r)
            DivFree: begin
               if ((start == DivStart) && !div_zero_s) begin
                  dividend_r <= mag1_s;
                  divisor_r  <= mag2_s;
                  rem_r      <= {DATA_W{1'b0}};
                  cnt_r      <= {CNT_W{1'b0}};
                  neg_q_r    <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                  neg_rem_r  <= signed_div & opdata1[DATA_W-1];
               end
            end
            DivByZero: begin
               result_r <= {(2*DATA_W){1'b0}};
               ready_r  <= DivResultReady;
            end
            DivOn: begin
               rem_r      <= step_rem_s;
               dividend_r <= quot_s;
               cnt_r      <= cnt_r + CNT_W'(1);
               if (last_step_s) begin
                  result_r <= {rem_fix_s, quot_fix_s};
                  ready_r  <= DivResultReady;
               end
            end
            DivEnd: begin
               ready_r <= DivResultNotReady;
            end
            default: begin
               ready_r <= DivResultNotReady;
            end
         endcase
      end
   end

   assign ready    = ready_r;
   assign result   = result_r;
   assign stallreq = start & ~ready_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues hand-computed results,
// and a negedge monitor pops and compares them whenever ready is high.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic        annul;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   typedef struct {
      logic [63:0] res;
      int          at;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic ready_q = 1'b0;

   div_unit dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
      .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
      .stallreq(stallreq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: scoreboard pops plus the ready/stallreq invariants.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("ready_single_pulse", {63'd0, ready & ready_q}, 64'd0);
         check("stall_while_ready", {63'd0, stallreq & ready}, 64'd0);
         if (ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready actual=%h required=no_pulse (cycle %0d)", result, cyc);
            end else begin
               e = sbq.pop_front();
               check({e.name, "_result"}, result, e.res);
               check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
            end
         end
      end
      ready_q = ready;
   end

   task automatic wait_ready(input int n, input bit chk_stall);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (chk_stall && (cyc == n || cyc == n + 32)) check("stallreq_busy", {63'd0, stallreq}, 64'd1);
         if (ready) begin
            if (chk_stall) check("stallreq_at_ready", {63'd0, stallreq}, 64'd0);
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=no_ready required=ready (cycle %0d)", cyc);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp_res, input int lat, input string nm,
                        input bit chk_stall);
      int n;
      @(posedge clk); #1;
      opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
      n = cyc;
      sbq.push_back('{res: exp_res, at: n + lat, name: nm});
      wait_ready(n, chk_stall);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic abort_test(input bit use_rst, input string nm);
      @(posedge clk); #1;
      opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0;
      if (use_rst) rst = 1'b1; else annul = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; annul = 1'b0;
      @(negedge clk);
      check({nm, "_ready"}, {63'd0, ready}, 64'd0);
      check({nm, "_result"}, result, 64'd0);
      repeat (40) @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
      opdata1 = 32'd0; opdata2 = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready", {63'd0, ready}, 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_stallreq", {63'd0, stallreq}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7", 1'b1);
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2", 1'b0);
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2", 1'b0);
      issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33, "div_m100_m7", 1'b0);
      issue(32'd3, 32'd5, 1'b0, {32'd3, 32'd0}, 33, "divu_3_5", 1'b0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1}, 33, "divu_max_max", 1'b0);
      issue(32'd5, 32'd0, 1'b0, 64'd0, 2, "div_by_zero", 1'b0);

      // Back-to-back: start held through END, operands switched in the following FREE cycle.
      @(posedge clk); #1;
      opdata1 = 32'hFFFF_FFFF; opdata2 = 32'h10; signed_div = 1'b0; start = 1'b1;
      n = cyc;
      sbq.push_back('{res: {32'hF, 32'h0FFF_FFFF}, at: n + 33, name: "b2b_first"});
      sbq.push_back('{res: {32'd0, 32'h8000_0000}, at: n + 67, name: "b2b_second"});
      wait_ready(n, 1'b0);
      @(posedge clk); #1;
      opdata1 = 32'h8000_0000; opdata2 = 32'hFFFF_FFFF; signed_div = 1'b1;
      wait_ready(n, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;

      abort_test(1'b0, "annul");
      issue(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33, "divu_9_4", 1'b0);
      abort_test(1'b1, "sync_rst");

      repeat (5) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
